cpu_run_monitor: RTL and testbench

Synthesizable run controller that replaces the fixed reset/wait/flush/dump sequencing of the CPU simulation bench with parametrised hardware. It holds the CPU in reset for a programmable number of cycles, counts execution cycles, detects the end-of-program instruction (or a timeout), lets the pipeline drain, then freezes the CPU and streams every data-memory word out over a valid/ready port. It sits beside `cpu`, observing the instruction bus and owning a dedicated read port on `dmem`.

---
 rtl/cpu_run_monitor_pkg.sv | 35 +++
 rtl/run_mon_timer.sv | 36 +++
 rtl/cpu_run_monitor.sv | 184 ++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_monitor_pkg
// Description : Shared state encoding, defaults and helpers for the run monitor
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_monitor_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RUN      = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_WT  = 3'd4,
        ST_DUMP_OUT = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [31:0] c_END_INSTR_DEFAULT = 32'h0000_0000;

    // Never returns less than 1 so derived vectors are always legal.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_mon_timer.sv
`default_nettype none
// ============================================================================
// Module      : run_mon_timer
// Description : Loadable down-counter with zero flag, shared by HOLD and FLUSH
// Revision    : 1.0 - initial release
// ============================================================================
module run_mon_timer
    import cpu_run_monitor_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int RESET_VAL = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadVal,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Stores N-1 so the flag is already up on the Nth edge after a load of N.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= WIDTH'(RESET_VAL - 1);
        end else if (i_load) begin
            r_count <= i_loadVal - 1'b1;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_monitor
// Description : CPU reset/run/flush sequencer with end detection, timeout and
//               valid/ready streaming dump of data memory
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int                 INSTR_W      = 32,
    parameter int                 DATA_W       = 64,
    parameter int                 DEPTH        = 512,
    parameter int                 CNT_W        = 32,
    parameter int                 RST_CYCLES   = 5,
    parameter int                 FLUSH_CYCLES = 5,
    parameter logic [INSTR_W-1:0] END_INSTR    = INSTR_W'(c_END_INSTR_DEFAULT),
    parameter int                 END_RUN      = 1,
    parameter longint             MAX_CYCLES   = 1048576,
    localparam int                ADDR_W       = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    output logic               cpu_reset,
    output logic               dump_mem_en,
    output logic [ADDR_W-1:0]  dump_addr,
    input  logic [DATA_W-1:0]  dump_rdata,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [ADDR_W-1:0]  out_index,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   cycles,
    output logic               timeout,
    output logic               done
);

    localparam int c_TMR_W = clog2(((RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES) + 1);
    localparam int c_RUN_W = clog2(END_RUN + 1);
    localparam logic [63:0] c_MAX_M1 = 64'(MAX_CYCLES - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [CNT_W-1:0]    r_cycCnt;
    logic [c_RUN_W-1:0]  r_runCnt;
    logic                r_cpuReset;
    logic                r_memEn;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_index;
    logic [CNT_W-1:0]    r_cycles;
    logic                r_timeout;
    logic                r_done;

    logic                w_isEnd;
    logic                w_endHit;
    logic                w_atMax;
    logic [CNT_W-1:0]    w_cycNext;
    logic                w_lastIdx;
    logic [ADDR_W-1:0]   w_idxNext;
    logic                w_tmrLoad;
    logic                w_tmrZero;

    assign w_isEnd   = (instruction == END_INSTR);
    assign w_endHit  = w_isEnd && (r_runCnt == c_RUN_W'(END_RUN - 1));
    // A limit beyond the counter range can never match, since the counter saturates.
    assign w_atMax   = (64'(r_cycCnt) == c_MAX_M1);
    assign w_cycNext = (&r_cycCnt) ? r_cycCnt : r_cycCnt + 1'b1;
    assign w_lastIdx = (r_idx == ADDR_W'(DEPTH - 1));
    assign w_idxNext = r_idx + 1'b1;
    assign w_tmrLoad = (r_state == ST_RUN) && (w_endHit || w_atMax);

    run_mon_timer #(
        .WIDTH     (c_TMR_W),
        .RESET_VAL (RST_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_tmrLoad),
        .i_loadVal (c_TMR_W'(FLUSH_CYCLES)),
        .o_zero    (w_tmrZero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_HOLD;
            r_idx      <= '0;
            r_cycCnt   <= '0;
            r_runCnt   <= '0;
            r_cpuReset <= 1'b1;
            r_memEn    <= 1'b0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_index    <= '0;
            r_cycles   <= '0;
            r_timeout  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_tmrZero) begin
                        r_state    <= ST_RUN;
                        r_cpuReset <= 1'b0;
                        r_cycCnt   <= '0;
                        r_runCnt   <= '0;
                    end
                end

                ST_RUN: begin
                    r_cycCnt <= w_cycNext;
                    r_runCnt <= w_isEnd ? r_runCnt + 1'b1 : '0;
                    // End detection takes priority over a coincident timeout.
                    if (w_endHit) begin
                        r_cycles <= r_cycCnt;
                        r_runCnt <= '0;
                        r_state  <= ST_FLUSH;
                    end else if (w_atMax) begin
                        r_cycles  <= r_cycCnt;
                        r_timeout <= 1'b1;
                        r_state   <= ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    if (w_tmrZero) begin
                        r_state    <= ST_DUMP_RD;
                        r_cpuReset <= 1'b1;
                        r_memEn    <= 1'b1;
                        r_addr     <= r_idx;
                    end
                end

                ST_DUMP_RD: begin
                    r_memEn <= 1'b0;
                    r_state <= ST_DUMP_WT;
                end

                ST_DUMP_WT: begin
                    r_data  <= dump_rdata;
                    r_index <= r_idx;
                    r_valid <= 1'b1;
                    r_state <= ST_DUMP_OUT;
                end

                ST_DUMP_OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (w_lastIdx) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= w_idxNext;
                            r_addr  <= w_idxNext;
                            r_memEn <= 1'b1;
                            r_state <= ST_DUMP_RD;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_DONE;
                end

                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign cpu_reset   = r_cpuReset;
    assign dump_mem_en = r_memEn;
    assign dump_addr   = r_addr;
    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign out_index   = r_index;
    assign cycles      = r_cycles;
    assign timeout     = r_timeout;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_monitor
// Description : Self-checking bench: small instance (DEPTH 8, END_RUN 2,
//               MAX_CYCLES 64) and full-size instance, scoreboarded dump
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_monitor;

    localparam int c_RST     = 5;
    localparam int c_FLUSH   = 5;
    localparam int c_DEPTH_S = 8;
    localparam int c_DEPTH_L = 512;

    typedef struct packed {
        int              startCyc;
        logic [3:0][31:0] pat;
        int              expCycles;
        logic            expTimeout;
    } runVec_t;

    typedef struct packed {
        logic [8:0]  idx;
        logic [63:0] data;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstS  = 1'b0;
    logic        rstL  = 1'b0;
    logic        sel   = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] instr = 32'h1;

    logic        cpuRstS, memEnS, validS, timeoutS, doneS;
    logic [2:0]  addrS, indexS;
    logic [63:0] dataS;
    logic [63:0] rdataS = '0;
    logic [31:0] cyclesS;

    logic        cpuRstL, memEnL, validL, timeoutL, doneL;
    logic [8:0]  addrL, indexL;
    logic [63:0] dataL;
    logic [63:0] rdataL = '0;
    logic [31:0] cyclesL;

    cpu_run_monitor #(
        .DEPTH      (c_DEPTH_S),
        .END_RUN    (2),
        .MAX_CYCLES (64)
    ) u_dutS (
        .clk         (clk),
        .reset       (rstS),
        .instruction (instr),
        .cpu_reset   (cpuRstS),
        .dump_mem_en (memEnS),
        .dump_addr   (addrS),
        .dump_rdata  (rdataS),
        .out_valid   (validS),
        .out_data    (dataS),
        .out_index   (indexS),
        .out_ready   (ready),
        .cycles      (cyclesS),
        .timeout     (timeoutS),
        .done        (doneS)
    );

    cpu_run_monitor #(
        .DEPTH (c_DEPTH_L)
    ) u_dutL (
        .clk         (clk),
        .reset       (rstL),
        .instruction (instr),
        .cpu_reset   (cpuRstL),
        .dump_mem_en (memEnL),
        .dump_addr   (addrL),
        .dump_rdata  (rdataL),
        .out_valid   (validL),
        .out_data    (dataL),
        .out_index   (indexL),
        .out_ready   (ready),
        .cycles      (cyclesL),
        .timeout     (timeoutL),
        .done        (doneL)
    );

    // Data memories holding i*0x1111, synchronous read with one cycle latency.
    always @(posedge clk) begin
        if (memEnS) rdataS <= 64'(addrS) * 64'h1111;
        if (memEnL) rdataL <= 64'(addrL) * 64'h1111;
    end

    logic        mCpuRst, mMemEn, mValid, mTimeout, mDone;
    logic [8:0]  mAddr, mIndex;
    logic [63:0] mData;
    logic [31:0] mCycles;

    always_comb begin
        mCpuRst  = sel ? cpuRstL  : cpuRstS;
        mMemEn   = sel ? memEnL   : memEnS;
        mValid   = sel ? validL   : validS;
        mTimeout = sel ? timeoutL : timeoutS;
        mDone    = sel ? doneL    : doneS;
        mAddr    = sel ? addrL    : {6'd0, addrS};
        mIndex   = sel ? indexL   : {6'd0, indexS};
        mData    = sel ? dataL    : dataS;
        mCycles  = sel ? cyclesL  : cyclesS;
    end

    int    tests = 0;
    int    fails = 0;
    word_t sbq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic runVec_t mkVec(input int s, input logic [31:0] p0, input logic [31:0] p1,
                                      input logic [31:0] p2, input logic [31:0] p3,
                                      input int e, input logic t);
        runVec_t v;
        v.startCyc   = s;
        v.pat[0]     = p0;
        v.pat[1]     = p1;
        v.pat[2]     = p2;
        v.pat[3]     = p3;
        v.expCycles  = e;
        v.expTimeout = t;
        return v;
    endfunction

    task automatic checkResetState(input string tag);
        check({tag, " rst cpu_reset"}, 64'(mCpuRst), 64'd1);
        check({tag, " rst dump_mem_en"}, 64'(mMemEn), 64'd0);
        check({tag, " rst dump_addr"}, 64'(mAddr), 64'd0);
        check({tag, " rst out_valid"}, 64'(mValid), 64'd0);
        check({tag, " rst out_data"}, mData, 64'd0);
        check({tag, " rst out_index"}, 64'(mIndex), 64'd0);
        check({tag, " rst cycles"}, 64'(mCycles), 64'd0);
        check({tag, " rst timeout"}, 64'(mTimeout), 64'd0);
        check({tag, " rst done"}, 64'(mDone), 64'd0);
    endtask

    task automatic doReset(input logic useL, input string tag);
        @(negedge clk);
        rstS  = 1'b0;
        rstL  = 1'b0;
        sel   = useL;
        instr = 32'h1;
        ready = 1'b0;
        #1 checkResetState(tag);
        @(negedge clk);
        if (useL) rstL = 1'b1;
        else      rstS = 1'b1;
    endtask

    // Leaves the bench at the negedge of the first DUMP_RD cycle.
    task automatic runPhase(input runVec_t v, input string tag);
        int n;
        int memEnAt;
        n = 0;
        while (mCpuRst && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " hold length"}, 64'(n), 64'(c_RST));
        memEnAt = -1;
        for (int c = 0; c < 200 && memEnAt < 0; c++) begin
            if (mMemEn) begin
                memEnAt = c;
            end else begin
                instr = 32'h1;
                if (v.startCyc >= 0 && c >= v.startCyc && c < v.startCyc + 4)
                    instr = v.pat[c - v.startCyc];
                if (c == v.expCycles + 1)
                    check({tag, " cycles latched at flush entry"}, 64'(mCycles), 64'(v.expCycles));
                if (c == v.expCycles + c_FLUSH)
                    check({tag, " cpu_reset low in last flush cycle"}, 64'(mCpuRst), 64'd0);
                @(negedge clk);
            end
        end
        check({tag, " end-to-dump_mem_en edges"}, 64'(memEnAt), 64'(v.expCycles + c_FLUSH + 1));
        check({tag, " cycles"}, 64'(mCycles), 64'(v.expCycles));
        check({tag, " timeout"}, 64'(mTimeout), 64'(v.expTimeout));
        check({tag, " cpu_reset in dump"}, 64'(mCpuRst), 64'd1);
        instr = 32'h0;
    endtask

    task automatic dumpPhase(input int depth, input int abortIdx, input logic toggleReady,
                             input string tag);
        int    nextRd;
        int    accepted;
        int    lastIdx;
        int    lastAcceptN;
        int    doneAt;
        logic  rdy;
        word_t w;
        nextRd      = 0;
        accepted    = 0;
        lastIdx     = -1;
        lastAcceptN = -10;
        doneAt      = -1;
        sbq.delete();
        for (int n = 0; n < 4 * depth + 20 && doneAt < 0; n++) begin
            if (mDone) begin
                doneAt = n;
            end else begin
                if (mMemEn) begin
                    check({tag, " read addr"}, 64'(mAddr), 64'(nextRd));
                    w.idx  = 9'(nextRd);
                    w.data = 64'(nextRd) * 64'h1111;
                    sbq.push_back(w);
                    nextRd++;
                end
                if (mValid) begin
                    if (sbq.size() == 0) begin
                        check({tag, " spurious out_valid"}, 64'(mValid), 64'd0);
                    end else begin
                        check({tag, " out_index"}, 64'(mIndex), 64'(sbq[0].idx));
                        check({tag, " out_data"}, mData, sbq[0].data);
                        if (abortIdx == int'(sbq[0].idx)) begin
                            if (sel) rstL = 1'b0;
                            else     rstS = 1'b0;
                            #1 checkResetState({tag, " mid-dump"});
                            return;
                        end
                    end
                end
                rdy   = toggleReady ? logic'(n % 2 == 0) : 1'b1;
                ready = rdy;
                if (mValid && rdy && sbq.size() > 0) begin
                    lastIdx     = int'(sbq[0].idx);
                    lastAcceptN = n;
                    void'(sbq.pop_front());
                    accepted++;
                end
                @(negedge clk);
            end
        end
        check({tag, " done seen"}, 64'(doneAt >= 0), 64'd1);
        check({tag, " done one edge after last accept"}, 64'(doneAt), 64'(lastAcceptN + 1));
        check({tag, " words accepted"}, 64'(accepted), 64'(depth));
        check({tag, " last index"}, 64'(lastIdx), 64'(depth - 1));
        check({tag, " scoreboard drained"}, 64'(sbq.size()), 64'd0);
        if (!toggleReady)
            check({tag, " dump length"}, 64'(doneAt), 64'(3 * depth));
        repeat (3) @(negedge clk);
        check({tag, " done held"}, 64'(mDone), 64'd1);
        check({tag, " no reads after done"}, 64'(mMemEn), 64'd0);
        check({tag, " no valid after done"}, 64'(mValid), 64'd0);
        ready = 1'b0;
    endtask

    initial begin
        runVec_t vecs[5];
        runVec_t vecL;
        vecs[0] = mkVec(10, 32'h0, 32'h1, 32'h0, 32'h0, 13, 1'b0);
        vecs[1] = mkVec(-1, 32'h1, 32'h1, 32'h1, 32'h1, 63, 1'b1);
        vecs[2] = mkVec(62, 32'h0, 32'h0, 32'h1, 32'h1, 63, 1'b0);
        vecs[3] = mkVec(0,  32'h0, 32'h0, 32'h1, 32'h1, 1,  1'b0);
        vecs[4] = mkVec(20, 32'h0, 32'h1, 32'h0, 32'h1, 63, 1'b1);
        vecL    = mkVec(37, 32'h0, 32'h1, 32'h1, 32'h1, 37, 1'b0);

        for (int i = 0; i < 5; i++) begin
            doReset(1'b0, $sformatf("S%0d", i));
            runPhase(vecs[i], $sformatf("S%0d", i));
            dumpPhase(c_DEPTH_S, -1, 1'b1, $sformatf("S%0d", i));
        end

        doReset(1'b0, "abort");
        runPhase(vecs[0], "abort");
        dumpPhase(c_DEPTH_S, 3, 1'b1, "abort");
        doReset(1'b0, "restart");
        runPhase(vecs[0], "restart");
        dumpPhase(c_DEPTH_S, -1, 1'b1, "restart");

        doReset(1'b1, "L");
        runPhase(vecL, "L");
        dumpPhase(c_DEPTH_L, -1, 1'b0, "L");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
